// File: rtl/qam_symbol_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : qam_symbol_scheduler
//  Purpose  : Packs an LSB-first byte stream into log2(POINTS)-bit symbol
//             indices and emits the matching {imag,real} constellation entry
//             on a registered valid/ready stream with frame/packet last flag.
//  Revision : 1.0  initial release
// ============================================================================
module qam_symbol_scheduler #(
  parameter int POINTS            = 16,
  parameter int INTEGER_PART      = 5,
  parameter int SYMBOLS_PER_FRAME = 64
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [POINTS-1:0][2*INTEGER_PART-1:0]          constellation_points,
  input  logic [7:0]                                     s_data,
  input  logic                                           s_valid,
  input  logic                                           s_last,
  output logic                                           s_ready,
  output logic [2*INTEGER_PART-1:0]                      m_data,
  output logic [$clog2(POINTS)-1:0]                      m_index,
  output logic                                           m_valid,
  output logic                                           m_last,
  input  logic                                           m_ready
);

  localparam int c_BPS = $clog2(POINTS);
  localparam int c_BW  = c_BPS + 7;
  localparam int c_CW  = $clog2(c_BW + 1);
  localparam int c_FW  = (SYMBOLS_PER_FRAME > 1) ? $clog2(SYMBOLS_PER_FRAME) : 1;
  localparam int c_DW  = 2 * INTEGER_PART;

  localparam logic [c_CW-1:0] c_CNT_BPS   = c_CW'(c_BPS);
  localparam logic [c_CW-1:0] c_CNT_BYTE  = c_CW'(8);
  localparam logic [c_FW-1:0] c_FRAME_END = c_FW'(SYMBOLS_PER_FRAME - 1);
  localparam logic [c_FW-1:0] c_FRAME_ONE = c_FW'(1);

  localparam logic [1:0] c_ST_FILL  = 2'd0;
  localparam logic [1:0] c_ST_EMIT  = 2'd1;
  localparam logic [1:0] c_ST_FLUSH = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [c_BW-1:0]  r_buf;
  logic [c_BW-1:0]  w_buf_nxt;
  logic [c_CW-1:0]  r_cnt;
  logic [c_CW-1:0]  w_cnt_nxt;
  logic [c_CW-1:0]  w_cnt_after;
  logic             r_flush;
  logic             w_flush_nxt;
  logic [c_FW-1:0]  r_frame_cnt;
  logic             r_m_valid;
  logic             r_m_last;
  logic [c_DW-1:0]  r_m_data;
  logic [c_BPS-1:0] r_m_index;
  logic             w_s_ready;
  logic             w_can_load;
  logic             w_slot_free;
  logic             w_load;
  logic             w_accept;
  logic             w_last_sym;
  logic [c_BPS-1:0] w_idx;
  logic [c_BW-1:0]  w_ins;

  assign w_slot_free = !r_m_valid || m_ready;
  assign w_load      = w_slot_free && w_can_load;
  assign w_accept    = s_valid && w_s_ready;
  // Bits above cnt are always zero, so the low BPS bits give a zero-padded index.
  assign w_idx       = r_buf[c_BPS-1:0];
  assign w_ins       = {{(c_BW-8){1'b0}}, s_data} << r_cnt;
  assign w_cnt_after = (r_cnt >= c_CNT_BPS) ? (r_cnt - c_CNT_BPS) : '0;
  assign w_last_sym  = (r_flush && (w_cnt_after == '0)) || (r_frame_cnt == c_FRAME_END);

  // Next buffer contents: a symbol load shifts bits out, a byte accept appends above.
  always_comb begin
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_cnt;
    w_flush_nxt = r_flush;
    if (w_load) begin
      w_buf_nxt = r_buf >> c_BPS;
      w_cnt_nxt = w_cnt_after;
      if (r_flush && (w_cnt_after == '0)) begin
        w_flush_nxt = 1'b0;
      end
    end else if (w_accept) begin
      w_buf_nxt   = r_buf | w_ins;
      w_cnt_nxt   = r_cnt + c_CNT_BYTE;
      w_flush_nxt = s_last;
    end
  end

  // State register: tracks whether the buffer is filling, emitting or draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state follows the next buffer occupancy and flush flag.
  always_comb begin
    w_state_nxt = c_ST_FILL;
    if (w_flush_nxt) begin
      w_state_nxt = c_ST_FLUSH;
    end else if (w_cnt_nxt >= c_CNT_BPS) begin
      w_state_nxt = c_ST_EMIT;
    end
  end

  // State outputs: accept bytes only while filling; load whenever bits are available.
  always_comb begin
    w_s_ready  = 1'b0;
    w_can_load = 1'b0;
    case (r_state)
      c_ST_FILL:  w_s_ready  = !rst;
      c_ST_EMIT:  w_can_load = 1'b1;
      c_ST_FLUSH: w_can_load = (r_cnt != '0);
      default:    ;
    endcase
  end

  // Bit buffer, occupancy count and packet flush flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      r_flush <= 1'b0;
    end else begin
      r_buf   <= w_buf_nxt;
      r_cnt   <= w_cnt_nxt;
      r_flush <= w_flush_nxt;
    end
  end

  // Frame symbol counter restarts after every symbol carrying last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_load) begin
      r_frame_cnt <= w_last_sym ? '0 : (r_frame_cnt + c_FRAME_ONE);
    end
  end

  // Output symbol register; the table is sampled only when a symbol is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
      r_m_index <= '0;
    end else if (w_load) begin
      r_m_valid <= 1'b1;
      r_m_last  <= w_last_sym;
      r_m_data  <= constellation_points[w_idx];
      r_m_index <= w_idx;
    end else if (w_slot_free) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end
  end

  assign s_ready = w_s_ready;
  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;
  assign m_data  = r_m_data;
  assign m_index = r_m_index;

endmodule
`default_nettype wire

// File: tb/tb_qam_symbol_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qam_symbol_scheduler
//  Purpose  : Self-checking bench; one scheduler per constellation size, each
//             compared against a bit-queue packing model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_qam_symbol_scheduler;

  localparam int c_NCFG = 8;
  localparam int c_DW   = 10;

  logic clk;
  int   n_err  = 0;
  int   n_chk  = 0;
  int   n_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  genvar gi;
  for (gi = 0; gi < c_NCFG; gi++) begin : g_cfg
    localparam int P   = (gi == 7) ? 16 : (4 << gi);
    localparam int SPF = (gi == 0) ? 7 : (gi == 1) ? 5 : (gi == 2) ? 64 : (gi == 3) ? 64 :
                         (gi == 4) ? 4 : (gi == 5) ? 6 : 3;
    localparam int BPS = $clog2(P);

    logic                      rst_l;
    logic [P-1:0][c_DW-1:0]    tbl;
    logic [7:0]                s_data;
    logic                      s_valid, s_last, s_ready;
    logic [c_DW-1:0]           m_data;
    logic [BPS-1:0]            m_index;
    logic                      m_valid, m_last, m_ready;
    int                        ready_mode;

    bit   bits[$];
    int   frame_n;
    int   exp_idx[$];
    bit   exp_last[$];
    bit   stall_seen;
    logic [c_DW-1:0] hold_data;
    logic [BPS-1:0]  hold_idx;
    logic            hold_last;

    qam_symbol_scheduler #(
      .POINTS(P), .INTEGER_PART(5), .SYMBOLS_PER_FRAME(SPF)
    ) u_dut (
      .clk(clk), .rst(rst_l), .constellation_points(tbl),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .m_data(m_data), .m_index(m_index), .m_valid(m_valid), .m_last(m_last),
      .m_ready(m_ready)
    );

    function automatic string tg(input string s);
      return $sformatf("P%0d/S%0d %s", P, SPF, s);
    endfunction

    function automatic void model_reset();
      bits.delete();
      exp_idx.delete();
      exp_last.delete();
      frame_n = 0;
    endfunction

    function automatic void emit(input int idx, input bit pkt_end);
      bit l;
      frame_n++;
      l = pkt_end || (frame_n == SPF);
      if (l) frame_n = 0;
      exp_idx.push_back(idx);
      exp_last.push_back(l);
    endfunction

    // Append a byte LSB first and cut every complete symbol; a packet end pads the tail.
    function automatic void model_push(input logic [7:0] b, input bit l);
      int v;
      int k;
      for (int j = 0; j < 8; j++) bits.push_back(b[j]);
      while (bits.size() >= BPS) begin
        v = 0;
        for (int j = 0; j < BPS; j++) v |= int'(bits.pop_front()) << j;
        emit(v, l && (bits.size() == 0));
      end
      if (l && (bits.size() > 0)) begin
        v = 0;
        k = 0;
        while (bits.size() > 0) begin
          v |= int'(bits.pop_front()) << k;
          k++;
        end
        emit(v, 1'b1);
      end
    endfunction

    task automatic send(input logic [7:0] b, input bit l);
      int  n;
      bit  acc;
      n   = 0;
      acc = 1'b0;
      s_data  = b;
      s_last  = l;
      s_valid = 1'b1;
      while (!acc && n < 300) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk);
        #1;
        n++;
      end
      check(tg("byte accepted"), acc, 1);
      if (acc) model_push(b, l);
      s_valid = 1'b0;
      s_last  = 1'b0;
    endtask

    task automatic drain();
      int n;
      n = 0;
      while (exp_idx.size() > 0 && n < 3000) begin
        @(posedge clk);
        n++;
      end
      check(tg("drain pending"), exp_idx.size(), 0);
      repeat (4) @(posedge clk);
      #1;
    endtask

    // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
    initial begin
      m_ready = 1'b1;
      forever begin
        @(posedge clk);
        #2;
        case (ready_mode)
          0:       m_ready = 1'b1;
          1:       m_ready = ($urandom_range(0, 9) < 7);
          default: m_ready = 1'b0;
        endcase
      end
    end

    // Output monitor: scoreboard on handshakes, hold-stability while stalled.
    initial begin
      int  ei;
      bit  el;
      stall_seen = 1'b0;
      forever begin
        @(negedge clk);
        if (rst_l) begin
          stall_seen = 1'b0;
        end else begin
          if (stall_seen) begin
            check(tg("stall m_valid"), m_valid, 1);
            check(tg("stall m_index"), m_index, hold_idx);
            check(tg("stall m_data"), m_data, hold_data);
            check(tg("stall m_last"), m_last, hold_last);
          end
          if (m_valid && m_ready) begin
            if (exp_idx.size() == 0) begin
              check(tg("spurious symbol"), exp_idx.size(), 1);
            end else begin
              ei = exp_idx.pop_front();
              el = exp_last.pop_front();
              check(tg("m_index"), m_index, ei);
              check(tg("m_data"), m_data, ei);
              check(tg("m_last"), m_last, el);
            end
          end
          stall_seen = m_valid && !m_ready;
          hold_idx   = m_index;
          hold_data  = m_data;
          hold_last  = m_last;
        end
      end
    end

    initial begin
      int g;
      rst_l      = 1'b1;
      s_valid    = 1'b0;
      s_data     = '0;
      s_last     = 1'b0;
      ready_mode = 0;
      model_reset();
      for (int k = 0; k < P; k++) tbl[k] = c_DW'(k);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check(tg("rst s_ready"), s_ready, 0);
      check(tg("rst m_valid"), m_valid, 0);
      check(tg("rst m_last"), m_last, 0);
      check(tg("rst m_data"), m_data, 0);
      check(tg("rst m_index"), m_index, 0);
      @(posedge clk);
      #1 rst_l = 1'b0;
      @(negedge clk);
      check(tg("s_ready after rst"), s_ready, 1);
      @(posedge clk);
      #1;

      // Two-byte packet, single saturated byte, and a three-byte run without last.
      send(8'hA5, 1'b0);
      send(8'h3C, 1'b1);
      drain();
      send(8'hFF, 1'b1);
      drain();
      send(8'h21, 1'b0);
      send(8'h43, 1'b0);
      send(8'h65, 1'b0);
      drain();

      // Downstream stall with a symbol held.
      ready_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      send(8'h5A, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      check(tg("stall held valid"), m_valid, 1);
      check(tg("stall s_ready"), s_ready,
            ((exp_idx.size() - 1) * BPS + bits.size()) < BPS);
      ready_mode = 0;
      drain();

      // Asynchronous reset while a packet is draining.
      ready_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      send(8'h77, 1'b1);
      repeat (2) @(posedge clk);
      #2 rst_l = 1'b1;
      #1;
      check(tg("async rst m_valid"), m_valid, 0);
      check(tg("async rst s_ready"), s_ready, 0);
      model_reset();
      ready_mode = 0;
      @(posedge clk);
      #1 rst_l = 1'b0;
      @(posedge clk);
      #1;
      send(8'h10, 1'b1);
      drain();

      // Randomised bytes, packet ends, source gaps and downstream stalls.
      ready_mode = 1;
      for (int n = 0; n < 60; n++) begin
        send(8'($urandom), ($urandom_range(0, 3) == 0));
        g = $urandom_range(0, 2);
        if (g > 0) begin
          repeat (g) @(posedge clk);
          #1;
        end
      end
      send(8'($urandom), 1'b1);
      ready_mode = 0;
      drain();
      n_done++;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (n_done < c_NCFG && cyc < 60000) begin
      @(posedge clk);
      cyc++;
    end
    check("all configurations finished", n_done, c_NCFG);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
